// File: rtl/ibex_mem_port_arbiter.sv
// N:1 round-robin arbiter merging Ibex-style req/gnt/rvalid hosts onto one
// memory port. A locked request is held on the bus until granted, and an
// in-order tracker routes every rvalid back to the host that issued it.
module ibex_mem_port_arbiter #(
    parameter int NumPorts       = 2,
    parameter int MaxOutstanding = 2,
    parameter int AddrW          = 32,
    parameter int DataW          = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumPorts-1:0]                    host_req_i,
    input  logic [NumPorts-1:0]                    host_we_i,
    input  logic [NumPorts*(DataW/8)-1:0]          host_be_i,
    input  logic [NumPorts*AddrW-1:0]              host_addr_i,
    input  logic [NumPorts*DataW-1:0]              host_wdata_i,
    input  logic [NumPorts*7-1:0]                  host_wdata_intg_i,
    output logic [NumPorts-1:0]                    host_gnt_o,
    output logic [NumPorts-1:0]                    host_rvalid_o,
    output logic [DataW-1:0]                       host_rdata_o,
    output logic [6:0]                             host_rdata_intg_o,
    output logic                                   host_err_o,
    output logic                                   mem_req_o,
    input  logic                                   mem_gnt_i,
    output logic                                   mem_we_o,
    output logic [DataW/8-1:0]                     mem_be_o,
    output logic [AddrW-1:0]                       mem_addr_o,
    output logic [DataW-1:0]                       mem_wdata_o,
    output logic [6:0]                             mem_wdata_intg_o,
    input  logic                                   mem_rvalid_i,
    input  logic [DataW-1:0]                       mem_rdata_i,
    input  logic [6:0]                             mem_rdata_intg_i,
    input  logic                                   mem_err_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
    output logic                                   unexp_rvalid_o
);
    localparam int BeW   = DataW / 8;
    localparam int IdxW  = $clog2(NumPorts);
    localparam int FifoW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW  = $clog2(MaxOutstanding + 1);

    typedef enum logic {ST_ARB, ST_HOLD} state_e;

    state_e            state_reg, state_next;
    logic [IdxW-1:0]   lock_reg, lock_next;
    logic [IdxW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IdxW-1:0]   fifo_mem [MaxOutstanding];
    logic [FifoW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CntW-1:0]   count_reg;

    logic [IdxW:0]     cand_sum [NumPorts];
    logic [IdxW-1:0]   cand_idx [NumPorts];
    logic [IdxW-1:0]   rr_sel, sel;
    logic              rr_found, req_raw, full, empty, push, pop;
    logic [IdxW-1:0]   head;

    assign full  = (count_reg == CntW'(MaxOutstanding));
    assign empty = (count_reg == '0);
    assign head  = fifo_mem[rd_ptr_reg];

    // Candidate gi is the host gi places after rr_ptr, wrapping at NumPorts.
    genvar gi;
    generate
        for (gi = 0; gi < NumPorts; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (IdxW+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (IdxW+1)'(NumPorts)) ?
                                  IdxW'(cand_sum[gi] - (IdxW+1)'(NumPorts)) :
                                  IdxW'(cand_sum[gi]);
        end
    endgenerate

    // First requester at or after rr_ptr (scan downward so the nearest wins).
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = rr_ptr_reg;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            if (host_req_i[cand_idx[k]]) begin
                rr_found = 1'b1;
                rr_sel   = cand_idx[k];
            end
        end
    end

    // Next-state and mux select: ARB picks round-robin, HOLD sticks to lock.
    always_comb begin
        state_next = state_reg;
        lock_next  = lock_reg;
        sel        = rr_sel;
        req_raw    = 1'b0;
        case (state_reg)
            ST_ARB: begin
                sel     = rr_sel;
                req_raw = rr_found & ~full;
                if (req_raw && !mem_gnt_i) begin
                    lock_next  = rr_sel;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                sel     = lock_reg;
                req_raw = host_req_i[lock_reg] & ~full;
                // A dropped request without grant abandons the lock, no push.
                if (mem_gnt_i || !host_req_i[lock_reg]) begin
                    state_next = ST_ARB;
                end
            end
            default: state_next = ST_ARB;
        endcase
    end

    // Outputs are quiet while reset is held; broadcast read data is not.
    always_comb begin
        mem_req_o        = req_raw & ~rst_i;
        push             = mem_req_o & mem_gnt_i;
        pop              = mem_rvalid_i & ~empty & ~rst_i;
        unexp_rvalid_o   = mem_rvalid_i & empty & ~rst_i;
        host_err_o       = mem_err_i & mem_rvalid_i & ~rst_i;
        host_gnt_o       = '0;
        host_rvalid_o    = '0;
        if (push) host_gnt_o[sel]    = 1'b1;
        if (pop)  host_rvalid_o[head] = 1'b1;
        mem_we_o         = 1'b0;
        mem_be_o         = '0;
        mem_addr_o       = '0;
        mem_wdata_o      = '0;
        mem_wdata_intg_o = '0;
        if (mem_req_o) begin
            mem_we_o         = host_we_i[sel];
            mem_be_o         = host_be_i[sel*BeW +: BeW];
            mem_addr_o       = host_addr_i[sel*AddrW +: AddrW];
            mem_wdata_o      = host_wdata_i[sel*DataW +: DataW];
            mem_wdata_intg_o = host_wdata_intg_i[sel*7 +: 7];
        end
        rr_ptr_next = rr_ptr_reg;
        if (push) rr_ptr_next = (sel == IdxW'(NumPorts - 1)) ? '0 : sel + 1'b1;
    end

    assign host_rdata_o      = mem_rdata_i;
    assign host_rdata_intg_o = mem_rdata_intg_i;
    assign outstanding_o     = count_reg;

    // Control state: FSM, lock, round-robin pointer, tracker pointers/count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= ST_ARB;
            lock_reg   <= '0;
            rr_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            lock_reg   <= lock_next;
            rr_ptr_reg <= rr_ptr_next;
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == FifoW'(MaxOutstanding - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == FifoW'(MaxOutstanding - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Tracker storage: issuing host of each granted transaction, in order.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= sel;
        end
    end
endmodule

// File: tb/tb_ibex_mem_port_arbiter.sv
// Self-checking bench for ibex_mem_port_arbiter: directed scenarios then
// random traffic, all checked against a queue-based transaction model.
module tb_ibex_mem_port_arbiter;
    localparam int N    = 3;
    localparam int MAXO = 2;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int CW   = $clog2(MAXO + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      host_req, host_we, host_gnt, host_rvalid;
    logic [N*DW/8-1:0] host_be;
    logic [N*AW-1:0]   host_addr;
    logic [N*DW-1:0]   host_wdata;
    logic [N*7-1:0]    host_wintg;
    logic [DW-1:0]     host_rdata, mem_rdata, mem_wdata;
    logic [6:0]        host_rintg, mem_wintg, mem_rintg;
    logic              host_err, mem_req, mem_gnt, mem_we, mem_rvalid, mem_err, unexp;
    logic [DW/8-1:0]   mem_be;
    logic [AW-1:0]     mem_addr;
    logic [CW-1:0]     outstanding;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of issuing hosts, rr pointer, locked host (-1 = none)
    int mq[$];
    int m_rr;
    int m_lock;

    // Values observed at the last step, for directed checks
    logic [N-1:0]  obs_gnt, obs_rvalid;
    logic          obs_req, obs_unexp;
    logic [AW-1:0] obs_addr;
    logic [CW-1:0] obs_out;

    always #5 clk = ~clk;

    ibex_mem_port_arbiter #(.NumPorts(N), .MaxOutstanding(MAXO), .AddrW(AW), .DataW(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata), .host_wdata_intg_i(host_wintg),
        .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
        .host_rdata_intg_o(host_rintg), .host_err_o(host_err),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wdata_intg_o(mem_wintg),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_rdata_intg_i(mem_rintg),
        .mem_err_i(mem_err), .outstanding_o(outstanding), .unexp_rvalid_o(unexp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rr   = 0;
        m_lock = -1;
    endtask

    // One cycle: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic step(input logic [N-1:0] r, input logic g, input logic rv, input logic er);
        int            sel_m;
        logic          xreq, xun, full_m;
        logic [N-1:0]  xgnt, xrv;
        logic [AW-1:0] xaddr;
        logic          xwe;
        host_req   = r;
        mem_gnt    = g;
        mem_rvalid = rv;
        mem_err    = er;
        mem_rdata  = $urandom;
        mem_rintg  = 7'($urandom);
        host_we    = N'($urandom);
        for (int i = 0; i < N; i++) host_addr[i*AW +: AW] = AW'($urandom);
        #4;
        full_m = (mq.size() == MAXO);
        sel_m  = -1;
        if (m_lock >= 0) begin
            sel_m = m_lock;
            xreq  = r[m_lock] && !full_m;
        end else begin
            if (!full_m) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_rr + k) % N;
                    if (sel_m < 0 && r[idx]) sel_m = idx;
                end
            end
            xreq = (sel_m >= 0);
        end
        xgnt = '0;
        if (xreq && g) xgnt[sel_m] = 1'b1;
        xrv = '0;
        xun = 1'b0;
        if (rv) begin
            if (mq.size() > 0) xrv[mq[0]] = 1'b1;
            else xun = 1'b1;
        end
        xaddr = xreq ? host_addr[sel_m*AW +: AW] : '0;
        xwe   = xreq ? host_we[sel_m] : 1'b0;
        obs_gnt = host_gnt; obs_rvalid = host_rvalid; obs_req = mem_req;
        obs_unexp = unexp; obs_addr = mem_addr; obs_out = outstanding;
        chk("mem_req", 64'(mem_req), 64'(xreq));
        chk("host_gnt", 64'(host_gnt), 64'(xgnt));
        chk("host_rvalid", 64'(host_rvalid), 64'(xrv));
        chk("unexp_rvalid", 64'(unexp), 64'(xun));
        chk("outstanding", 64'(outstanding), 64'(mq.size()));
        chk("mem_addr", 64'(mem_addr), 64'(xaddr));
        chk("mem_we", 64'(mem_we), 64'(xwe));
        chk("host_err", 64'(host_err), 64'(er && rv));
        chk("rdata_bcast", 64'(host_rdata), 64'(mem_rdata));
        @(posedge clk);
        if (rv && mq.size() > 0) void'(mq.pop_front());
        if (xreq && g) begin
            mq.push_back(sel_m);
            m_rr   = (sel_m + 1) % N;
            m_lock = -1;
        end else if (m_lock >= 0 && !r[m_lock]) begin
            m_lock = -1;
        end else if (m_lock < 0 && xreq) begin
            m_lock = sel_m;
        end
        #1;
        $display("step req=%b gnt=%b rv=%b -> host_gnt=%b host_rvalid=%b unexp=%b out=%0d",
                 r, g, rv, obs_gnt, obs_rvalid, obs_unexp, obs_out);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req"}, 64'(mem_req), 64'(0));
        chk({tag, "_gnt"}, 64'(host_gnt), 64'(0));
        chk({tag, "_rvalid"}, 64'(host_rvalid), 64'(0));
        chk({tag, "_out"}, 64'(outstanding), 64'(0));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        host_req = '0; host_we = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
        mem_rdata = '0; mem_rintg = '0;
        for (int i = 0; i < N; i++) begin
            host_addr[i*AW +: AW]      = AW'(16'h1000 * (i + 1));
            host_be[i*(DW/8) +: DW/8]  = 4'hF;
            host_wdata[i*DW +: DW]     = 32'hA000_0000 + i;
            host_wintg[i*7 +: 7]       = 7'(i + 1);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;

        // Two hosts requesting every cycle: grants alternate, rvalid follows
        for (int c = 0; c < 6; c++) begin
            step(3'b011, 1'b1, (c > 0), 1'b0);
            chk("alt_gnt", 64'(obs_gnt), 64'(3'b001 << (c % 2)));
            if (c > 0) chk("alt_rvalid", 64'(obs_rvalid), 64'(3'b001 << ((c - 1) % 2)));
        end
        step(3'b000, 1'b0, 1'b1, 1'b0);
        chk("alt_last_rvalid", 64'(obs_rvalid), 64'(3'b010));

        // Lock: host1 held while memory stalls, host0 waits behind it
        step(3'b010, 1'b0, 1'b0, 1'b0);
        chk("lock_addr0", 64'(obs_addr), 64'(host_addr[AW +: AW]));
        for (int c = 0; c < 2; c++) begin
            step(3'b011, 1'b0, 1'b0, 1'b0);
            chk("lock_addr_hold", 64'(obs_addr), 64'(host_addr[AW +: AW]));
        end
        step(3'b011, 1'b1, 1'b0, 1'b0);
        chk("lock_gnt1", 64'(obs_gnt), 64'(3'b010));
        step(3'b001, 1'b1, 1'b0, 1'b0);
        chk("lock_then_gnt0", 64'(obs_gnt), 64'(3'b001));
        step(3'b000, 1'b0, 1'b1, 1'b0);
        step(3'b000, 1'b0, 1'b1, 1'b1);

        // Full tracker: no request until a slot frees, no same-cycle bypass
        step(3'b001, 1'b1, 1'b0, 1'b0);
        step(3'b001, 1'b1, 1'b0, 1'b0);
        step(3'b001, 1'b1, 1'b0, 1'b0);
        chk("full_req", 64'(obs_req), 64'(0));
        chk("full_out", 64'(obs_out), 64'(2));
        step(3'b001, 1'b1, 1'b1, 1'b0);
        chk("full_pop_nobypass", 64'(obs_req), 64'(0));
        step(3'b001, 1'b1, 1'b0, 1'b0);
        chk("full_resume", 64'(obs_gnt), 64'(3'b001));
        step(3'b000, 1'b0, 1'b1, 1'b0);
        step(3'b000, 1'b0, 1'b1, 1'b0);

        // Grant to host0 while host1's earlier response returns
        step(3'b010, 1'b1, 1'b0, 1'b0);
        step(3'b001, 1'b1, 1'b1, 1'b0);
        chk("pushpop_rvalid", 64'(obs_rvalid), 64'(3'b010));
        chk("pushpop_gnt", 64'(obs_gnt), 64'(3'b001));
        step(3'b000, 1'b0, 1'b1, 1'b0);
        chk("pushpop_out", 64'(obs_out), 64'(1));

        // Response with nothing outstanding
        step(3'b000, 1'b0, 1'b1, 1'b0);
        chk("unexp_pulse", 64'(obs_unexp), 64'(1));
        chk("unexp_no_rvalid", 64'(obs_rvalid), 64'(0));

        // Reset with two outstanding, then a stale response
        step(3'b011, 1'b1, 1'b0, 1'b0);
        step(3'b011, 1'b1, 1'b0, 1'b0);
        host_req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        rst = 1'b1;
        #4;
        check_quiet("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3'b000, 1'b0, 1'b1, 1'b0);
        chk("stale_unexp", 64'(obs_unexp), 64'(1));
        step(3'b011, 1'b1, 1'b0, 1'b0);
        chk("post_rst_gnt0", 64'(obs_gnt), 64'(3'b001));
        step(3'b000, 1'b0, 1'b1, 1'b0);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            step(N'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0 ? 0 : $urandom),
                 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
